// File: rtl/huff_code_accum_if.sv
// Bit-serial accumulator bus: code-bit load and decoded-length consume towards the
// accumulator, accumulated bits, count and flags back.
interface huff_code_accum_if #(
  parameter int MAX_CODE = 9,
  parameter int CNT_W    = 4
);
  logic                load;
  logic                in_bit;
  logic                consume;
  logic [CNT_W-1:0]    consume_len;
  logic [MAX_CODE-1:0] bits;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                overflow;
  logic                in_ready;

  modport master (
    output load, in_bit, consume, consume_len,
    input  bits, count, full, overflow, in_ready
  );

  modport slave (
    input  load, in_bit, consume, consume_len,
    output bits, count, full, overflow, in_ready
  );
endinterface

// File: rtl/huff_code_accum.sv
// Huffman code-bit accumulator: one-cycle load latency, consume applied before load.
// in_ready drops when full unless a non-empty consume frees room; a load while full is dropped and sets overflow.
module huff_code_accum #(
  parameter int MAX_CODE  = 9,
  parameter int CNT_W     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            reset,
  huff_code_accum_if.slave acc
);

  logic [MAX_CODE-1:0] bits_q, bits_d, post_bits;
  logic [CNT_W-1:0]    count_q, count_d, c_post, shamt;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                cons_eff;

  always_comb begin
    cons_eff  = acc.consume && (acc.consume_len != '0);
    c_post    = count_q;
    if (cons_eff) begin
      c_post = (acc.consume_len < count_q) ? (count_q - acc.consume_len) : '0;
    end
    shamt     = count_q - c_post;

    // Oldest bit sits at count-1 (MSB-first) or at bit 0 (LSB-first).
    post_bits = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < MAX_CODE; i++) begin
        if (i < int'(c_post)) post_bits[i] = bits_q[i];
      end
    end else begin
      post_bits = bits_q >> shamt;
    end

    bits_d  = post_bits;
    count_d = c_post;
    ovf_d   = cons_eff ? 1'b0 : ovf_q;

    if (acc.load) begin
      if (c_post < CNT_W'(MAX_CODE)) begin
        if (MSB_FIRST != 0) begin
          bits_d = {post_bits[MAX_CODE-2:0], acc.in_bit};
        end else begin
          for (int i = 0; i < MAX_CODE; i++) begin
            if (i == int'(c_post)) bits_d[i] = acc.in_bit;
          end
        end
        count_d = c_post + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    full_d = (count_d == CNT_W'(MAX_CODE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bits_q  <= bits_d;
      count_q <= count_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc.bits     = bits_q;
  assign acc.count    = count_q;
  assign acc.full     = full_q;
  assign acc.overflow = ovf_q;
  assign acc.in_ready = (count_q < CNT_W'(MAX_CODE)) || cons_eff;

endmodule

// File: tb/tb_huff_code_accum.sv
// Bench for huff_code_accum: both bit orders side by side against a bit-queue reference model.
module tb_huff_code_accum;
  localparam int MAXC = 9;
  localparam int CW   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  huff_code_accum_if #(.MAX_CODE(MAXC), .CNT_W(CW)) if_m ();
  huff_code_accum_if #(.MAX_CODE(MAXC), .CNT_W(CW)) if_l ();

  huff_code_accum #(.MAX_CODE(MAXC), .CNT_W(CW), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .acc(if_m));
  huff_code_accum #(.MAX_CODE(MAXC), .CNT_W(CW), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .acc(if_l));

  always #5 clk = ~clk;

  typedef struct {
    logic [MAXC-1:0] bm;
    logic [MAXC-1:0] bl;
    int              cnt;
    bit              full;
    bit              ovf;
  } exp_t;

  exp_t exp_q[$];
  bit   mq[$];      // held code bits, oldest first
  bit   m_ovf;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [MAXC-1:0] render(input bit msb);
    logic [MAXC-1:0] v;
    int n;
    v = '0;
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      if (msb) v[n-1-i] = mq[i];
      else     v[i]     = mq[i];
    end
    return v;
  endfunction

  task automatic drive(input bit ld, input bit b, input bit cs, input int len);
    if_m.load = ld; if_m.in_bit = b; if_m.consume = cs; if_m.consume_len = CW'(len);
    if_l.load = ld; if_l.in_bit = b; if_l.consume = cs; if_l.consume_len = CW'(len);
  endtask

  // One clock of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic cyc(input bit ld, input bit b, input bit cs, input int len);
    exp_t e;
    bit   rdy;
    bit   d;
    @(negedge clk);
    drive(ld, b, cs, len);
    rdy = (mq.size() < MAXC) || (cs && len > 0);
    if (cs && len > 0) begin
      for (int k = 0; k < len && mq.size() > 0; k++) d = mq.pop_front();
      m_ovf = 1'b0;
    end
    if (ld) begin
      if (mq.size() < MAXC) mq.push_back(b);
      else                  m_ovf = 1'b1;
    end
    e.bm   = render(1'b1);
    e.bl   = render(1'b0);
    e.cnt  = mq.size();
    e.full = (mq.size() == MAXC);
    e.ovf  = m_ovf;
    exp_q.push_back(e);
    #1;
    chk("in_ready_msb", int'(if_m.in_ready), int'(rdy));
    chk("in_ready_lsb", int'(if_l.in_ready), int'(rdy));
    @(posedge clk);
    #2;
  endtask

  // Reset asserted between edges with state held; outputs must clear before any edge.
  task automatic reset_mid();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_bits_msb", int'(if_m.bits), 0);
    chk("arst_bits_lsb", int'(if_l.bits), 0);
    chk("arst_count",    int'(if_m.count), 0);
    chk("arst_full",     int'(if_m.full), 0);
    chk("arst_ovf",      int'(if_m.overflow), 0);
    @(posedge clk);
    #1;
    chk("arst_hold_count", int'(if_m.count) + int'(if_l.count), 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 0);
    mq.delete();
    m_ovf = 1'b0;
    reset = 1'b1;
  endtask

  // Scoreboard monitor: compares every registered output one step after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bits_msb",  int'(if_m.bits),     int'(e.bm));
        chk("bits_lsb",  int'(if_l.bits),     int'(e.bl));
        chk("count_msb", int'(if_m.count),    e.cnt);
        chk("count_lsb", int'(if_l.count),    e.cnt);
        chk("full_msb",  int'(if_m.full),     int'(e.full));
        chk("full_lsb",  int'(if_l.full),     int'(e.full));
        chk("ovf_msb",   int'(if_m.overflow), int'(e.ovf));
        chk("ovf_lsb",   int'(if_l.overflow), int'(e.ovf));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[7];
    pat = '{1, 0, 1, 1, 0, 0, 0};
    drive(1'b0, 1'b0, 1'b0, 0);
    m_ovf = 1'b0;
    #3;
    chk("reset_bits",  int'(if_m.bits) + int'(if_l.bits), 0);
    chk("reset_count", int'(if_m.count), 0);
    chk("reset_flags", int'(if_m.full) + int'(if_m.overflow), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) cyc(1'b1, pat[i][0], 1'b0, 0);
    chk("seq_bits_msb",  int'(if_m.bits),  9'b001011000);
    chk("seq_bits_lsb",  int'(if_l.bits),  9'b000001101);
    chk("seq_count",     int'(if_m.count), 7);
    chk("seq_full",      int'(if_m.full),  0);

    cyc(1'b1, 1'b1, 1'b1, 3);
    chk("cons_load_bits",  int'(if_m.bits),     9'b000010001);
    chk("cons_load_count", int'(if_m.count),    5);
    chk("cons_load_ovf",   int'(if_m.overflow), 0);

    reset_mid();
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("first_after_rst", int'(if_m.count), 1);
    for (int i = 1; i < 9; i++) cyc(1'b1, 1'b1, 1'b0, 0);
    chk("fill_bits",     int'(if_m.bits),     9'h1FF);
    chk("fill_count",    int'(if_m.count),    9);
    chk("fill_full",     int'(if_m.full),     1);
    chk("fill_in_ready", int'(if_m.in_ready), 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("drop_bits",  int'(if_m.bits),     9'h1FF);
    chk("drop_count", int'(if_m.count),    9);
    chk("drop_ovf",   int'(if_m.overflow), 1);
    cyc(1'b0, 1'b0, 1'b1, 0);
    chk("zero_len_ovf",   int'(if_m.overflow), 1);
    chk("zero_len_count", int'(if_m.count),    9);
    cyc(1'b0, 1'b0, 1'b1, 1);
    chk("clr_ovf",   int'(if_m.overflow), 0);
    chk("clr_count", int'(if_m.count),    8);

    reset_mid();
    cyc(1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("lsb_bits",  int'(if_l.bits),  9'b000000011);
    chk("lsb_count", int'(if_l.count), 3);
    cyc(1'b0, 1'b0, 1'b1, 1);
    chk("lsb_cons_bits",  int'(if_l.bits),  9'b000000001);
    chk("lsb_cons_count", int'(if_l.count), 2);

    cyc(1'b0, 1'b0, 1'b1, 2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, 6);
    chk("over_cons_count", int'(if_m.count),    0);
    chk("over_cons_bits",  int'(if_m.bits) + int'(if_l.bits), 0);
    chk("over_cons_ovf",   int'(if_m.overflow), 0);

    for (int i = 0; i < 800; i++) begin
      if (i == 400) reset_mid();
      cyc(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 12)));
    end
    cyc(1'b0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
